// File: rtl/color_cmd_decoder_if.sv
// Byte stream in from the UART receiver and the address/data write
// handshake out to the color register file.
// master: the decoder (consumes bytes, drives the write request).
// slave : the environment (drives bytes and ack, observes the request).
interface color_cmd_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] address;
  logic [3:0] data;
  logic       valid;
  logic       ack;

  modport master (
    input  rx_data,
    input  rx_valid,
    input  ack,
    output address,
    output data,
    output valid
  );

  modport slave (
    output rx_data,
    output rx_valid,
    output ack,
    input  address,
    input  data,
    input  valid
  );
endinterface

// File: rtl/color_cmd_decoder.sv
// color_cmd_decoder: parses 4-byte frames {0x43, addr, data, checksum}
// from the UART byte stream and issues one register write per good frame
// over a valid/ack handshake. Bad, stalled or overrun frames are dropped
// and reported on a one-cycle err strobe with a sticky err_code.
module color_cmd_decoder #(
  parameter int unsigned TIMEOUT = 1_000_000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic         clk,
  input  logic         rst,
  color_cmd_if.master  bus,
  output logic         err,
  output logic [1:0]   err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_SEND
  } state_t;

  localparam logic [7:0]       HDR_BYTE   = 8'h43;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       E_OVERRUN  = 2'd0;
  localparam logic [1:0]       E_TIMEOUT  = 2'd1;
  localparam logic [1:0]       E_FIELD    = 2'd2;
  localparam logic [1:0]       E_CHECKSUM = 2'd3;

  // Address and data bytes carry a 4-bit value in the low nibble only.
  function automatic logic field_ok(input logic [7:0] b);
    return (b[7:4] == 4'h0);
  endfunction

  // Expected checksum for a frame built from the latched fields.
  function automatic logic [7:0] frame_chk(input logic [3:0] a,
                                           input logic [3:0] d);
    return HDR_BYTE ^ {4'h0, a} ^ {4'h0, d};
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       addr_sh_q, addr_sh_d;
  logic [3:0]       data_sh_q, data_sh_d;
  logic [3:0]       address_q, address_d;
  logic [3:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  // Events decided by the next-state logic and consumed by the output logic.
  logic             in_frame;
  logic             timeout_hit;
  logic             load_req;
  logic             done_req;
  logic             fire_err;
  logic [1:0]       fire_code;

  assign in_frame    = (state_q == S_ADDR) || (state_q == S_DATA) ||
                       (state_q == S_CHK);
  assign timeout_hit = in_frame && !bus.rx_valid && (cnt_q == CNT_LAST);

  // State register and all other flops; reset drops any pending request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      address_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      address_q  <= address_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state logic: frame parsing, shadow capture, timeout and error events.
  always_comb begin
    state_d   = state_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    load_req  = 1'b0;
    done_req  = 1'b0;
    fire_err  = 1'b0;
    fire_code = E_OVERRUN;

    unique case (state_q)
      S_IDLE: begin
        // Only the header byte resynchronises; anything else is noise.
        if (bus.rx_valid && (bus.rx_data == HDR_BYTE)) begin
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (bus.rx_valid) begin
          if (field_ok(bus.rx_data)) begin
            addr_sh_d = bus.rx_data[3:0];
            state_d   = S_DATA;
          end else begin
            state_d   = S_IDLE;
            fire_err  = 1'b1;
            fire_code = E_FIELD;
          end
        end else if (timeout_hit) begin
          state_d   = S_IDLE;
          fire_err  = 1'b1;
          fire_code = E_TIMEOUT;
        end
      end

      S_DATA: begin
        if (bus.rx_valid) begin
          if (field_ok(bus.rx_data)) begin
            data_sh_d = bus.rx_data[3:0];
            state_d   = S_CHK;
          end else begin
            state_d   = S_IDLE;
            fire_err  = 1'b1;
            fire_code = E_FIELD;
          end
        end else if (timeout_hit) begin
          state_d   = S_IDLE;
          fire_err  = 1'b1;
          fire_code = E_TIMEOUT;
        end
      end

      S_CHK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == frame_chk(addr_sh_q, data_sh_q)) begin
            load_req = 1'b1;
            state_d  = S_SEND;
          end else begin
            state_d   = S_IDLE;
            fire_err  = 1'b1;
            fire_code = E_CHECKSUM;
          end
        end else if (timeout_hit) begin
          state_d   = S_IDLE;
          fire_err  = 1'b1;
          fire_code = E_TIMEOUT;
        end
      end

      S_SEND: begin
        // A byte arriving while a write is pending cannot be buffered.
        if (bus.rx_valid) begin
          fire_err  = 1'b1;
          fire_code = E_OVERRUN;
        end
        if (bus.ack) begin
          done_req = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The idle counter only runs between bytes of a frame; any byte, any
    // exit from the frame states and the timeout itself restart it at zero.
    if (in_frame && !bus.rx_valid && !timeout_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Output logic: register-file request and the error strobe/code.
  always_comb begin
    address_d  = address_q;
    data_d     = data_q;
    valid_d    = valid_q;
    err_d      = fire_err;
    err_code_d = err_code_q;

    if (load_req) begin
      address_d = addr_sh_q;
      data_d    = data_sh_q;
      valid_d   = 1'b1;
    end else if (done_req) begin
      valid_d   = 1'b0;
    end

    if (fire_err) begin
      err_code_d = fire_code;
    end
  end

  assign bus.address = address_q;
  assign bus.data    = data_q;
  assign bus.valid   = valid_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: doc/color_cmd_decoder.md
# color_cmd_decoder

Upstream feeder of the color processing stage. Parses framed 4-byte color-register write commands from the UART receiver byte stream. Checks each frame, then drives the 4-bit `address`/`data` + `valid`/`ack` write handshake into the color register file. Malformed, timed-out and overrun frames are dropped and reported on a one-cycle error strobe.

## Interface
- `TIMEOUT`, default 1_000_000: maximum idle cycles between bytes of one frame (10 ms at 100 MHz).
- `CNT_W`, default 20: timeout counter width; must satisfy 2^CNT_W ≥ TIMEOUT.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  received byte; valid only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `ack`  in  1  write accepted by the register file.
- `address`  out  4  register address, registered.
- `data`  out  4  register data, registered.
- `valid`  out  1  write request, held until `ack`.
- `err`  out  1  one-cycle error strobe.
- `err_code`  out  2  error cause, valid when `err`=1:
  - 0 = overrun.
  - 1 = timeout.
  - 2 = bad field.
  - 3 = checksum.

## Operation
- Frame format, in order:
  - Header 0x43 ('C').
  - Address byte {4'h0, addr}.
  - Data byte {4'h0, data}.
  - Checksum byte = 0x43 ^ addr_byte ^ data_byte.
- FSM states: IDLE, ADDR, DATA, CHK, SEND.
- IDLE:
  - `rx_valid` with 0x43 → ADDR.
  - Any other byte is ignored silently, with no `err`.
- ADDR:
  - Byte upper nibble ≠ 0 → IDLE, err code 2.
  - Otherwise latch the low nibble into the address shadow → DATA.
- DATA:
  - Same upper-nibble check (err code 2 on failure).
  - Otherwise latch the data shadow → CHK.
- CHK:
  - Byte ≠ computed checksum → IDLE, err code 3.
  - Otherwise load `address`/`data` from the shadows, set `valid` → SEND.
- SEND:
  - `address`/`data`/`valid` are held stable.
  - `ack`=1 → clear `valid`, go to IDLE.
  - Any `rx_valid` in SEND → byte dropped, err code 0, state unchanged.
- Timeout:
  - Counter cleared on every accepted byte and on entry to ADDR.
  - Increments each cycle in ADDR/DATA/CHK.
  - Counter == TIMEOUT-1 with `rx_valid`=0 → IDLE, err code 1.
  - If `rx_valid`=1 in that same cycle, the byte is processed normally and no timeout fires.
- `ack` outside SEND is ignored.
- Error in ADDR/DATA/CHK discards the partial frame. A 0x43 received in ADDR/DATA is treated as a field value, not a resync. IDLE alone handles resync.
- Reset values:
  - `address`=0, `data`=0, `valid`=0, `err`=0, `err_code`=0.
  - FSM=IDLE, counter=0, shadows=0.
- Reset asserted mid-frame or during SEND: immediate return to reset values, with no `err`. A pending request is lost.

## Timing
- Checksum byte strobe at cycle n → `valid`=1 and new `address`/`data` visible at n+1.
- `ack` sampled high at cycle m → `valid`=0 at m+1, and the FSM is in IDLE at m+1.
- Earliest next header is accepted at m+1. Minimum frame-to-frame spacing is therefore 4 byte strobes + handshake.
- `err` asserts the cycle after the offending byte or the timeout cycle, and lasts exactly 1 cycle. `err_code` is registered alongside `err` and holds its value afterwards.
- `ack` in the same cycle that `valid` first rises (cycle n+1) is honored: `valid` drops at n+2.
- Overrun and `ack` in the same SEND cycle: the handshake completes and `err` (code 0) also pulses.

## Test plan
- Reset then frame 43 05 0A 4C (0x43^0x05^0x0A=0x4C) → `valid`=1 at cycle after 4C with `address`=5, `data`=A. Hold `ack`=0 for 10 cycles: outputs stable. `ack`=1 → `valid`=0 next cycle.
- Frame 43 05 0A 00 → no `valid`, `err` pulse with `err_code`=3. Following good frame 43 01 02 40 → `address`=1, `data`=2.
- Frame 43 15 … → `err`=1, `err_code`=2 after byte 15. Subsequent bytes 0A 4C are ignored in IDLE with no `err`.
- `TIMEOUT`=16: send 43 05, then 16 idle cycles → `err`, `err_code`=1, FSM in IDLE. Repeat with a byte arriving exactly at counter 15 → no timeout.
- Good frame, `ack` withheld, extra byte 43 during SEND → `err_code`=0 pulse, `valid` still 1 and data unchanged. Then `ack` → completion.
- Assert `rst` low after 43 05 and again while `valid`=1 → all outputs 0 immediately, no `err`. After release, a good frame is accepted normally.
